// File: rtl/cache_bank_requester.sv
// ---------------------------------------------------------------------------
// cache_bank_requester
//
// Initiator side of a single-bank cache request/acknowledge link. Load
// addresses from the core are queued in a small FIFO and issued one at a
// time to the bank as single-cycle Cache_Req pulses. The block then waits
// for the one-cycle Cache_Ack, captures the data and returns it to the
// core as a one-cycle response pulse. A request that is never acknowledged
// is abandoned after TIMEOUT wait cycles and reported with Core_Resp_Err.
//
// Ports
//   CLK, RST            clock (rising edge) and asynchronous active-high reset
//   Core_Req_Valid/Addr core request; accepted when Core_Req_Ready is high
//   Core_Req_Ready      FIFO has room (occupancy below DEPTH)
//   Core_Resp_Valid     one-cycle response pulse
//   Core_Resp_Addr/Data address and data of the response (data 0 on error)
//   Core_Resp_Err       response is a timeout
//   Cache_Req           one-cycle request pulse to the bank
//   Cache_AddrOut       request address, held until the request completes
//   Cache_Ack/DataIn    bank acknowledge and data
//   Pending_Count       FIFO occupancy including the in-flight entry
//   Stray_Ack_Count     acks seen while idle, saturating at 255
// ---------------------------------------------------------------------------
module cache_bank_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Core_Req_Valid,
    input  logic [ADDR_W-1:0]          Core_Req_Addr,
    output logic                       Core_Req_Ready,
    output logic                       Core_Resp_Valid,
    output logic [ADDR_W-1:0]          Core_Resp_Addr,
    output logic [DATA_W-1:0]          Core_Resp_Data,
    output logic                       Core_Resp_Err,
    output logic                       Cache_Req,
    output logic [ADDR_W-1:0]          Cache_AddrOut,
    input  logic                       Cache_Ack,
    input  logic [DATA_W-1:0]          Cache_DataIn,
    output logic [$clog2(DEPTH):0]     Pending_Count,
    output logic [7:0]                 Stray_Ack_Count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              req_reg, req_next;
    logic [ADDR_W-1:0] addr_out_reg, addr_out_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [ADDR_W-1:0] resp_addr_reg, resp_addr_next;
    logic [DATA_W-1:0] resp_data_reg, resp_data_next;
    logic              resp_err_reg, resp_err_next;
    logic [7:0]        stray_reg, stray_next;

    logic push;
    logic pop;

    // Ready is held low while reset is asserted so that every output reads
    // zero during reset; it rises as soon as reset is released.
    assign Core_Req_Ready = !RST && (count_reg < CNT_W'(DEPTH));
    assign push           = Core_Req_Valid && Core_Req_Ready;

    // FIFO storage: no reset, so it can map onto RAM resources. Contents
    // are meaningless after reset because the pointers and count restart.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= Core_Req_Addr;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally since DEPTH is a
    // power of two. The head stays in the FIFO while in flight and is only
    // popped when its request completes (ack or timeout).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            req_reg        <= 1'b0;
            addr_out_reg   <= '0;
            resp_valid_reg <= 1'b0;
            resp_addr_reg  <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            stray_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            req_reg        <= req_next;
            addr_out_reg   <= addr_out_next;
            resp_valid_reg <= resp_valid_next;
            resp_addr_reg  <= resp_addr_next;
            resp_data_reg  <= resp_data_next;
            resp_err_reg   <= resp_err_next;
            stray_reg      <= stray_next;
        end
    end

    // Next-state logic. Cache_Req, Core_Resp_Valid and Core_Resp_Err default
    // to 0 so each is a single-cycle pulse; the bank would treat a second
    // high cycle of Cache_Req as a duplicate request.
    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        req_next        = 1'b0;
        addr_out_next   = addr_out_reg;
        resp_valid_next = 1'b0;
        resp_addr_next  = resp_addr_reg;
        resp_data_next  = resp_data_reg;
        resp_err_next   = 1'b0;
        stray_next      = stray_reg;
        pop             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Late acks (after a timeout or a reset) land here.
                if (Cache_Ack && (stray_reg != 8'hFF)) begin
                    stray_next = stray_reg + 8'd1;
                end
                if (count_reg != '0) begin
                    req_next      = 1'b1;
                    addr_out_next = fifo_mem[rd_ptr_reg];
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack on the timeout cycle wins and completes normally.
                if (Cache_Ack) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = Cache_DataIn;
                    resp_addr_next  = addr_out_reg;
                    pop             = 1'b1;
                    state_next      = ST_IDLE;
                end else if (wait_cnt_reg == WCNT_W'(TIMEOUT - 1)) begin
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    resp_data_next  = '0;
                    resp_addr_next  = addr_out_reg;
                    pop             = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Cache_Req       = req_reg;
    assign Cache_AddrOut   = addr_out_reg;
    assign Core_Resp_Valid = resp_valid_reg;
    assign Core_Resp_Addr  = resp_addr_reg;
    assign Core_Resp_Data  = resp_data_reg;
    assign Core_Resp_Err   = resp_err_reg;
    assign Pending_Count   = count_reg;
    assign Stray_Ack_Count = stray_reg;

endmodule

// File: tb/tb_cache_bank_requester.sv
// ---------------------------------------------------------------------------
// tb_cache_bank_requester
//
// Drives core requests and emulates a cache bank of configurable latency.
// A queue-based model (pending addresses, in-flight age, stray-ack count)
// predicts every output cycle by cycle; a few literal expectations pin the
// headline timing numbers.
// ---------------------------------------------------------------------------
module tb_cache_bank_requester;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              CLK;
    logic              RST;
    logic              Core_Req_Valid;
    logic [ADDR_W-1:0] Core_Req_Addr;
    logic              Core_Req_Ready;
    logic              Core_Resp_Valid;
    logic [ADDR_W-1:0] Core_Resp_Addr;
    logic [DATA_W-1:0] Core_Resp_Data;
    logic              Core_Resp_Err;
    logic              Cache_Req;
    logic [ADDR_W-1:0] Cache_AddrOut;
    logic              Cache_Ack;
    logic [DATA_W-1:0] Cache_DataIn;
    logic [2:0]        Pending_Count;
    logic [7:0]        Stray_Ack_Count;

    cache_bank_requester #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Core_Req_Valid (Core_Req_Valid),
        .Core_Req_Addr  (Core_Req_Addr),
        .Core_Req_Ready (Core_Req_Ready),
        .Core_Resp_Valid(Core_Resp_Valid),
        .Core_Resp_Addr (Core_Resp_Addr),
        .Core_Resp_Data (Core_Resp_Data),
        .Core_Resp_Err  (Core_Resp_Err),
        .Cache_Req      (Cache_Req),
        .Cache_AddrOut  (Cache_AddrOut),
        .Cache_Ack      (Cache_Ack),
        .Cache_DataIn   (Cache_DataIn),
        .Pending_Count  (Pending_Count),
        .Stray_Ack_Count(Stray_Ack_Count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bank contents: fixed function of the address.
    function automatic logic [31:0] bank_data(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    // ---------------- reference model + compare process ----------------
    logic [ADDR_W-1:0] mq[$];
    bit   outst   = 1'b0;
    int   age     = 0;
    int   stray_m = 0;
    int   dut_req_cnt  = 0;
    int   dut_resp_cnt = 0;
    int   dut_err_cnt  = 0;

    initial begin
        logic              exp_req, exp_resp, exp_err, push_s;
        logic [ADDR_W-1:0] exp_addr;
        forever begin
            @(posedge CLK);
            #1;
            if (Cache_Req)       dut_req_cnt++;
            if (Core_Resp_Valid) dut_resp_cnt++;
            if (Core_Resp_Valid && Core_Resp_Err) dut_err_cnt++;
            if (RST) begin
                mq.delete();
                outst   = 1'b0;
                age     = 0;
                stray_m = 0;
                chk("rst_req",        Cache_Req,       0);
                chk("rst_addr_out",   Cache_AddrOut,   0);
                chk("rst_resp_valid", Core_Resp_Valid, 0);
                chk("rst_resp_err",   Core_Resp_Err,   0);
                chk("rst_resp_addr",  Core_Resp_Addr,  0);
                chk("rst_resp_data",  Core_Resp_Data,  0);
                chk("rst_pending",    Pending_Count,   0);
                chk("rst_stray",      Stray_Ack_Count, 0);
                chk("rst_ready",      Core_Req_Ready,  0);
            end else begin
                push_s   = Core_Req_Valid && (mq.size() < DEPTH);
                exp_req  = !outst && (mq.size() > 0);
                exp_resp = 1'b0;
                exp_err  = 1'b0;
                exp_addr = '0;
                if (outst) begin
                    age++;
                    if (Cache_Ack) exp_resp = 1'b1;
                    else if (age == TIMEOUT) begin
                        exp_resp = 1'b1;
                        exp_err  = 1'b1;
                    end
                end else if (Cache_Ack && stray_m < 255) begin
                    stray_m++;
                end
                if (exp_resp) begin
                    exp_addr = mq.pop_front();
                    outst    = 1'b0;
                end
                if (exp_req) begin
                    outst = 1'b1;
                    age   = 0;
                end
                if (push_s) mq.push_back(Core_Req_Addr);

                chk("req", Cache_Req, exp_req);
                if (outst) chk("addr_out", Cache_AddrOut, mq[0]);
                chk("resp_valid", Core_Resp_Valid, exp_resp);
                chk("resp_err", Core_Resp_Err, exp_err);
                if (exp_resp) begin
                    chk("resp_addr", Core_Resp_Addr, exp_addr);
                    chk("resp_data", Core_Resp_Data, exp_err ? 32'h0 : bank_data(exp_addr));
                end
                chk("pending", Pending_Count, mq.size());
                chk("ready", Core_Req_Ready, mq.size() < DEPTH);
                chk("stray", Stray_Ack_Count, stray_m);
            end
        end
    end

    // ---------------- stimulus and bank emulation ----------------
    int                bank_lat  = 1;  // 0: never acknowledges
    bit                bank_rand = 1'b0;
    int                ack_cd    = 0;
    logic [ADDR_W-1:0] ack_addr;

    // Advance to the next falling edge and update the bank. A request seen
    // after edge e is acknowledged in the cycle after edge e+1+lat.
    task automatic tick();
        @(negedge CLK);
        Cache_Ack    = 1'b0;
        Cache_DataIn = $urandom;
        if (ack_cd > 0) begin
            ack_cd--;
            if (ack_cd == 0) begin
                Cache_Ack    = 1'b1;
                Cache_DataIn = bank_data(ack_addr);
            end
        end
        if (Cache_Req && !RST) begin
            if (bank_rand) bank_lat = $urandom_range(1, 3);
            if (bank_lat != 0) begin
                ack_cd   = bank_lat + 1;
                ack_addr = Cache_AddrOut;
            end
        end
    endtask

    // Returns at the falling edge after the accepting rising edge.
    task automatic push(input logic [ADDR_W-1:0] a);
        int n = 0;
        Core_Req_Valid = 1'b1;
        Core_Req_Addr  = a;
        while (!Core_Req_Ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL push_wait: ready never rose for addr 0x%0h", a);
        end
        tick();
        Core_Req_Valid = 1'b0;
        Core_Req_Addr  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (Pending_Count != 0 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain: pending stuck at %0d, required 0", Pending_Count);
        end
        repeat (6) tick();
    endtask

    initial begin
        int req0, resp0, err0, n;
        RST            = 1'b1;
        Core_Req_Valid = 1'b0;
        Core_Req_Addr  = '0;
        Cache_Ack      = 1'b0;
        Cache_DataIn   = '0;
        repeat (3) tick();
        chk("lit_ready_in_reset", Core_Req_Ready, 0);
        RST = 1'b0;
        #1;
        chk("lit_ready_after_reset", Core_Req_Ready, 1);
        tick();

        // Single load, bank latency 1
        bank_lat = 1;
        push(32'h0000_0040);
        tick();
        chk("lit_single_req", Cache_Req, 1);
        chk("lit_single_addr_out", Cache_AddrOut, 32'h40);
        tick();
        chk("lit_single_req_pulse", Cache_Req, 0);
        tick();
        tick();
        chk("lit_single_resp_valid", Core_Resp_Valid, 1);
        chk("lit_single_resp_data", Core_Resp_Data, 32'hDEAD_BEEF);
        chk("lit_single_resp_addr", Core_Resp_Addr, 32'h40);
        chk("lit_single_resp_err", Core_Resp_Err, 0);
        $display("single load: resp data 0x%0h", Core_Resp_Data);
        drain();

        // Full FIFO with a slow bank
        bank_lat = 10;
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i) * 4);
        chk("lit_full_pending", Pending_Count, 4);
        chk("lit_full_ready", Core_Req_Ready, 0);
        push(32'h1010);
        $display("full fifo: fifth push accepted, pending %0d", Pending_Count);
        drain();

        // Push in the same cycle the head completes, occupancy 2
        bank_lat = 3;
        push(32'h2000);
        push(32'h2004);
        n = 0;
        while (!(Cache_Ack && Pending_Count == 2) && n < 50) begin
            tick();
            n++;
        end
        chk("lit_simul_found", n < 50, 1);
        Core_Req_Valid = 1'b1;
        Core_Req_Addr  = 32'h2008;
        tick();
        Core_Req_Valid = 1'b0;
        chk("lit_simul_pending", Pending_Count, 2);
        $display("simultaneous push/pop: pending %0d", Pending_Count);
        drain();

        // Timeout, then a late ack two cycles later
        bank_lat = 0;
        push(32'h100);
        repeat (15) tick();
        chk("lit_to_not_yet", Core_Resp_Valid, 0);
        tick();
        chk("lit_to_resp_valid", Core_Resp_Valid, 1);
        chk("lit_to_resp_err", Core_Resp_Err, 1);
        chk("lit_to_resp_data", Core_Resp_Data, 0);
        chk("lit_to_resp_addr", Core_Resp_Addr, 32'h100);
        tick();
        Cache_Ack = 1'b1;
        tick();
        chk("lit_to_stray", Stray_Ack_Count, 1);
        $display("timeout: err %0b stray %0d", Core_Resp_Err, Stray_Ack_Count);
        drain();

        // Reset while waiting with three entries queued
        bank_lat = 5;
        push(32'h3000);
        push(32'h3004);
        push(32'h3008);
        chk("lit_prerst_pending", Pending_Count, 3);
        RST = 1'b1;
        #1;
        chk("lit_rst_pending", Pending_Count, 0);
        chk("lit_rst_req", Cache_Req, 0);
        chk("lit_rst_resp_valid", Core_Resp_Valid, 0);
        chk("lit_rst_addr_out", Cache_AddrOut, 0);
        tick();
        tick();
        RST = 1'b0;
        repeat (4) tick();
        chk("lit_rst_late_stray", Stray_Ack_Count, 1);
        $display("reset mid-wait: stray %0d pending %0d", Stray_Ack_Count, Pending_Count);
        drain();

        // 100 random requests, random bank latency 1..3
        bank_rand = 1'b1;
        req0  = dut_req_cnt;
        resp0 = dut_resp_cnt;
        err0  = dut_err_cnt;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            push($urandom);
        end
        drain();
        chk("rand_req_count", dut_req_cnt - req0, 100);
        chk("rand_resp_count", dut_resp_cnt - resp0, 100);
        chk("rand_err_count", dut_err_cnt - err0, 0);
        $display("random: %0d reqs %0d resps", dut_req_cnt - req0, dut_resp_cnt - resp0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
